eth_hdr_tx: RTL and testbench

ETH_HDR_TX -- requirements
Module: eth_hdr_tx

---
 rtl/eth_hdr_tx.sv | 129 ++++++++++++
 tb/tb_eth_hdr_tx.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_hdr_tx.sv
// Ethernet header transmitter: serialises a 14-byte Ethernet header ahead of the
// payload stream into a single registered AXI-Stream byte output.
module eth_hdr_tx #(
  parameter int TUSER_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   s_eth_hdr_valid,
  output logic                   s_eth_hdr_ready,
  input  logic [47:0]            s_eth_dest_mac,
  input  logic [47:0]            s_eth_src_mac,
  input  logic [15:0]            s_eth_type,

  input  logic [7:0]             s_eth_payload_axis_tdata,
  input  logic                   s_eth_payload_axis_tvalid,
  output logic                   s_eth_payload_axis_tready,
  input  logic                   s_eth_payload_axis_tlast,
  input  logic [TUSER_WIDTH-1:0] s_eth_payload_axis_tuser,

  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,

  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

  state_t                  state, state_n;
  logic [3:0]              idx, idx_n;
  logic [111:0]            hdr, hdr_n;
  logic [7:0]              tdata_n;
  logic                    tvalid_n, tlast_n;
  logic [TUSER_WIDTH-1:0]  tuser_n;
  logic                    stage_load;

  assign stage_load                = !m_axis_tvalid || m_axis_tready;
  assign s_eth_hdr_ready           = (state == IDLE) && !rst;
  assign s_eth_payload_axis_tready = (state == PAYLOAD) && stage_load;
  assign busy                      = (state != IDLE);

  // The latched header is a shift register; its top byte is always the next
  // header byte to emit. Byte 0 goes straight into the stage on the handshake
  // when the stage is free so it appears the very next cycle.
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    hdr_n    = hdr;
    tdata_n  = m_axis_tdata;
    tlast_n  = m_axis_tlast;
    tuser_n  = m_axis_tuser;
    tvalid_n = m_axis_tvalid;

    if (stage_load) begin
      tvalid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (s_eth_hdr_valid && s_eth_hdr_ready) begin
          state_n = HEADER;
          idx_n   = 4'd0;
          hdr_n   = {s_eth_dest_mac, s_eth_src_mac, s_eth_type};
          if (stage_load) begin
            tdata_n  = s_eth_dest_mac[47:40];
            tlast_n  = 1'b0;
            tuser_n  = '0;
            tvalid_n = 1'b1;
            hdr_n    = {s_eth_dest_mac[39:0], s_eth_src_mac, s_eth_type, 8'h00};
            idx_n    = 4'd1;
          end
        end
      end
      HEADER: begin
        if (stage_load) begin
          tdata_n  = hdr[111:104];
          tlast_n  = 1'b0;
          tuser_n  = '0;
          tvalid_n = 1'b1;
          hdr_n    = {hdr[103:0], 8'h00};
          if (idx == 4'd13) begin
            idx_n   = 4'd0;
            state_n = PAYLOAD;
          end else begin
            idx_n = idx + 4'd1;
          end
        end
      end
      PAYLOAD: begin
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready) begin
          tdata_n  = s_eth_payload_axis_tdata;
          tlast_n  = s_eth_payload_axis_tlast;
          tuser_n  = s_eth_payload_axis_tuser;
          tvalid_n = 1'b1;
          if (s_eth_payload_axis_tlast) begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 4'd0;
      hdr           <= '0;
      m_axis_tdata  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= '0;
    end else begin
      state         <= state_n;
      idx           <= idx_n;
      hdr           <= hdr_n;
      m_axis_tdata  <= tdata_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tlast  <= tlast_n;
      m_axis_tuser  <= tuser_n;
    end
  end

endmodule

// File: tb/tb_eth_hdr_tx.sv
// Scoreboard bench for eth_hdr_tx: expected beats are queued as frames are
// issued and popped as the DUT transfers them on m_axis.
module tb_eth_hdr_tx;

  localparam int TW = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_eth_hdr_valid = 1'b0;
  logic          s_eth_hdr_ready;
  logic [47:0]   s_eth_dest_mac = '0;
  logic [47:0]   s_eth_src_mac = '0;
  logic [15:0]   s_eth_type = '0;
  logic [7:0]    s_eth_payload_axis_tdata = '0;
  logic          s_eth_payload_axis_tvalid = 1'b0;
  logic          s_eth_payload_axis_tready;
  logic          s_eth_payload_axis_tlast = 1'b0;
  logic [TW-1:0] s_eth_payload_axis_tuser = '0;
  logic [7:0]    m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [TW-1:0] m_axis_tuser;
  logic          busy;

  eth_hdr_tx #(.TUSER_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .s_eth_hdr_valid(s_eth_hdr_valid), .s_eth_hdr_ready(s_eth_hdr_ready),
    .s_eth_dest_mac(s_eth_dest_mac), .s_eth_src_mac(s_eth_src_mac), .s_eth_type(s_eth_type),
    .s_eth_payload_axis_tdata(s_eth_payload_axis_tdata),
    .s_eth_payload_axis_tvalid(s_eth_payload_axis_tvalid),
    .s_eth_payload_axis_tready(s_eth_payload_axis_tready),
    .s_eth_payload_axis_tlast(s_eth_payload_axis_tlast),
    .s_eth_payload_axis_tuser(s_eth_payload_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    d;
    logic          l;
    logic [TW-1:0] u;
  } beat_t;

  beat_t      exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         frame_beats = 0;
  int         hs_cyc = -1;
  int         first_beat_cyc = -1;
  int         last_beat_cyc = -1;
  int         tlast_acc_cyc = -1;
  int         b2b_gap = -1;
  logic       tready_toggle = 1'b0;
  logic [7:0] payload [0:31];

  // Downstream ready: constantly high, or alternating every cycle when toggling.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tready_toggle) m_axis_tready = ~m_axis_tready;
      else               m_axis_tready = 1'b1;
    end
  end

  // Monitor samples on the falling edge, i.e. what the next rising edge will transfer.
  initial begin
    logic       stalled;
    beat_t      hold, act, e;
    stalled = 1'b0;
    hold = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        frame_beats = 0;
        stalled = 1'b0;
      end else begin
        act.d = m_axis_tdata;
        act.l = m_axis_tlast;
        act.u = m_axis_tuser;
        if (stalled) begin
          checks++;
          if (m_axis_tvalid !== 1'b1 || act !== hold) begin
            errors++;
            $display("[TB] FAIL hold_stable: got v=%b %h/%b/%b, need v=1 %h/%b/%b",
                     m_axis_tvalid, act.d, act.l, act.u, hold.d, hold.l, hold.u);
          end
        end
        if (s_eth_hdr_valid && s_eth_hdr_ready) begin
          if (tlast_acc_cyc >= 0) b2b_gap = cyc - tlast_acc_cyc;
          hs_cyc = cyc;
        end
        if (s_eth_payload_axis_tvalid && s_eth_payload_axis_tready) begin
          checks++;
          if (frame_beats < 13) begin
            errors++;
            $display("[TB] FAIL payload_early: accepted after %0d header beats, need >= 13", frame_beats);
          end
          if (s_eth_payload_axis_tlast) tlast_acc_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_beat: got %h/%b/%b, need no beat", act.d, act.l, act.u);
          end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
              errors++;
              $display("[TB] FAIL beat: got %h/%b/%b, need %h/%b/%b", act.d, act.l, act.u, e.d, e.l, e.u);
            end
          end
          frame_beats++;
          if (frame_beats == 1) first_beat_cyc = cyc;
          if (m_axis_tlast) begin
            last_beat_cyc = cyc;
            frame_beats = 0;
          end
        end
        stalled = m_axis_tvalid && !m_axis_tready;
        hold = act;
      end
    end
  end

  task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int base, input int n, input logic [TW-1:0] u);
    logic [111:0] h;
    beat_t b;
    h = {d, s, t};
    for (int i = 0; i < 14; i++) begin
      b.d = h[111 - 8*i -: 8];
      b.l = 1'b0;
      b.u = '0;
      exp_q.push_back(b);
    end
    for (int i = 0; i < n; i++) begin
      b.d = payload[base + i];
      b.l = (i == n - 1);
      b.u = (i == n - 1) ? u : '0;
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_header(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input bit keep_valid);
    bit done;
    done = 1'b0;
    s_eth_hdr_valid = 1'b1;
    s_eth_dest_mac = d;
    s_eth_src_mac = s;
    s_eth_type = t;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (s_eth_hdr_ready) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL hdr_timeout: got ready=0, need ready=1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    if (!keep_valid) s_eth_hdr_valid = 1'b0;
  endtask

  task automatic drive_payload(input int base, input int n, input logic [TW-1:0] u);
    bit done;
    for (int i = 0; i < n; i++) begin
      s_eth_payload_axis_tvalid = 1'b1;
      s_eth_payload_axis_tdata = payload[base + i];
      s_eth_payload_axis_tlast = (i == n - 1);
      s_eth_payload_axis_tuser = (i == n - 1) ? u : '0;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
        @(negedge clk);
        if (s_eth_payload_axis_tready) done = 1'b1;
      end
      if (!done) begin
        checks++;
        errors++;
        $display("[TB] FAIL payload_timeout: got tready=0, need tready=1 within 300 cycles");
      end
      @(posedge clk);
      #1;
    end
    s_eth_payload_axis_tvalid = 1'b0;
    s_eth_payload_axis_tlast = 1'b0;
    s_eth_payload_axis_tuser = '0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !m_axis_tvalid) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain: got %0d beats pending, need 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_stage: got v=%b l=%b u=%b d=%h, need all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata);
    end
    checks++;
    if ({busy, s_eth_payload_axis_tready, s_eth_hdr_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got busy/ptready/hready=%b%b%b, need 000",
               busy, s_eth_payload_axis_tready, s_eth_hdr_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (s_eth_hdr_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got hready=%b busy=%b, need 1 0", s_eth_hdr_ready, busy);
    end
  endtask

  task automatic test_basic_frame();
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33; payload[3] = 8'h44;
    push_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 0, 4, '0);
    fork
      drive_header(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 1'b0);
      drive_payload(0, 4, '0);
    join
    wait_drain();
    checks++;
    if (first_beat_cyc !== hs_cyc + 1) begin
      errors++;
      $display("[TB] FAIL first_byte_latency: got %0d cycles, need 1", first_beat_cyc - hs_cyc);
    end
    checks++;
    if (last_beat_cyc - first_beat_cyc !== 17) begin
      errors++;
      $display("[TB] FAIL frame_span: got %0d cycles, need 17", last_beat_cyc - first_beat_cyc);
    end
  endtask

  task automatic test_stall();
    tready_toggle = 1'b1;
    push_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 0, 4, '0);
    fork
      drive_header(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 1'b0);
      drive_payload(0, 4, '0);
    join
    wait_drain();
    tready_toggle = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_payload_first();
    for (int i = 0; i < 6; i++) payload[i] = 8'($urandom_range(0, 255));
    push_frame(48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h86DD, 0, 6, '0);
    fork
      drive_payload(0, 6, '0);
      begin
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (s_eth_payload_axis_tready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL idle_ptready: got %b, need 0", s_eth_payload_axis_tready);
        end
        drive_header(48'h0011_2233_4455, 48'hA0B1_C2D3_E4F5, 16'h86DD, 1'b0);
      end
    join
    wait_drain();
  endtask

  task automatic test_back_to_back();
    payload[0] = 8'hA1; payload[1] = 8'hA2; payload[2] = 8'hA3;
    payload[3] = 8'hB1; payload[4] = 8'hB2; payload[5] = 8'hB3; payload[6] = 8'hB4; payload[7] = 8'hB5;
    b2b_gap = -1;
    tlast_acc_cyc = -1;
    push_frame(48'h1111_2222_3333, 48'h4444_5555_6666, 16'h0806, 0, 3, 1'b1);
    push_frame(48'h7777_8888_9999, 48'hAAAA_BBBB_CCCC, 16'h88B5, 3, 5, '0);
    fork
      begin
        drive_header(48'h1111_2222_3333, 48'h4444_5555_6666, 16'h0806, 1'b1);
        drive_header(48'h7777_8888_9999, 48'hAAAA_BBBB_CCCC, 16'h88B5, 1'b0);
      end
      begin
        drive_payload(0, 3, 1'b1);
        drive_payload(3, 5, '0);
      end
    join
    wait_drain();
    checks++;
    if (b2b_gap !== 1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got %0d cycles, need 1", b2b_gap);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit done;
    payload[0] = 8'h5A; payload[1] = 8'hA5;
    push_frame(48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h1234, 0, 2, '0);
    drive_header(48'h0102_0304_0506, 48'h0708_090A_0B0C, 16'h1234, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (frame_beats == 7) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL mid_wait: got %0d header beats, need 7", frame_beats);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || s_eth_hdr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset: got tvalid=%b busy=%b hready=%b, need 0 0 0",
               m_axis_tvalid, busy, s_eth_hdr_ready);
    end
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
    payload[0] = 8'hC3; payload[1] = 8'h3C; payload[2] = 8'h99;
    push_frame(48'hDEAD_BEEF_0001, 48'hCAFE_F00D_0002, 16'h0800, 0, 3, '0);
    fork
      drive_header(48'hDEAD_BEEF_0001, 48'hCAFE_F00D_0002, 16'h0800, 1'b0);
      drive_payload(0, 3, '0);
    join
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_payload_first();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
